wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/rv_pkg.sv | 11 +
 rtl/rr_arb2.sv | 24 ++
 rtl/wb_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared widths and writeback request type for the register-file writeback path
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 32;
  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef struct packed {
    reg_idx_t rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter whose readies never depend on the requester's own valid
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_rdy_a,
  output logic o_rdy_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);
  logic r_ptr_a;
  // each ready looks only at the other side's valid and the pointer
  always_comb begin
    o_rdy_a = !i_req_b || r_ptr_a;
    o_rdy_b = !i_req_a || !r_ptr_a;
    o_gnt_a = i_req_a && o_rdy_a;
    o_gnt_b = i_req_b && o_rdy_b;
  end
  // pointer flips only on contention, handing priority to that cycle's loser
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ptr_a <= 1'b1;
    else if (i_req_a && i_req_b) r_ptr_a <= !r_ptr_a;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU/LSU writebacks onto one registered RF write port and tracks pending registers
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] sb_rs1,
  input  logic [REG_AW-1:0] sb_rs2,
  output logic              sb_rs1_busy,
  output logic              sb_rs2_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addD,
  output logic [XLEN-1:0]   rf_wdata
);
  import rv_pkg::*;
  localparam int NR = 1 << REG_AW;
  logic            w_alu_gnt;
  logic            w_lsu_gnt;
  logic            w_acc;
  wb_req_t         w_req;
  logic [NR-1:0]   w_set;
  logic [NR-1:0]   w_clr;
  logic            r_we;
  logic [REG_AW-1:0] r_addd;
  logic [XLEN-1:0] r_wdata;
  logic [NR-1:0]   r_busy;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_a (alu_valid),
    .i_req_b (lsu_valid),
    .o_rdy_a (alu_ready),
    .o_rdy_b (lsu_ready),
    .o_gnt_a (w_alu_gnt),
    .o_gnt_b (w_lsu_gnt)
  );
  // select the winner and form scoreboard set/clear masks; x0 is never marked pending
  always_comb begin
    w_acc = w_alu_gnt || w_lsu_gnt;
    w_req.rd = w_alu_gnt ? alu_rd : lsu_rd;
    w_req.data = w_alu_gnt ? alu_data : lsu_data;
    w_set = (iss_valid && iss_rd != '0) ? NR'(1) << iss_rd : '0;
    w_clr = r_we ? NR'(1) << r_addd : '0;
  end
  // one-cycle writeback register; rd = 0 is acknowledged but never writes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we <= 1'b0;
      r_addd <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_acc && w_req.rd != '0;
      if (w_acc) begin
        r_addd <= w_req.rd;
        r_wdata <= w_req.data;
      end
    end
  // pending bits clear on the commit edge; a same-edge issue to that register wins
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_busy <= '0;
    else r_busy <= w_set | (r_busy & ~w_clr);
  assign sb_rs1_busy = r_busy[sb_rs1];
  assign sb_rs2_busy = r_busy[sb_rs2];
  assign rf_we = r_we;
  assign rf_addD = r_addd;
  assign rf_wdata = r_wdata;
endmodule
